mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 177 +++++++++++++++++
 tb/tb_mem_arb.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// Two-requester arbiter in front of a single-port memory controller; all outputs registered.
// Ties are round-robin unless MEM_ARB_FIXED_PRIO_EN is defined (requester 0 then always wins).
module mem_arb #(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned AW     = 11
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WE0,
    input  logic          WE1,
    input  logic [AW-1:0] ADDR0,
    input  logic [AW-1:0] ADDR1,
    input  logic [7:0]    WDATA0,
    input  logic [7:0]    WDATA1,
    output logic          GNT0,
    output logic          GNT1,
    output logic          RVALID0,
    output logic          RVALID1,
    output logic [7:0]    RDATA,
    output logic          BUSY,
    output logic [AW-1:0] ADDR,
    output logic          CE,
    output logic          CSB,
    output logic          WEB,
    output logic          OEB,
    output logic [7:0]    IDATA,
    input  logic [7:0]    ODATA
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait} state_e;

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic          id_q, id_d;
    logic          grant, winner, rd_done;
    logic          acc_d, wait_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic          last_q, last_d;
`endif

    logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic          busy_q, busy_d;
    logic          ce_q, ce_d, csb_q, csb_d, web_q, web_d, oeb_q, oeb_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    idata_q, idata_d, rdata_q, rdata_d;

    // Arbitration: winner is only meaningful while grant is high.
    always_comb begin
        grant = (state_q == StIdle) && (REQ0 || REQ1);
`ifdef MEM_ARB_FIXED_PRIO_EN
        winner = !REQ0;
`else
        winner = (REQ0 && REQ1) ? !last_q : REQ1;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            id_q      <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q    <= 1'b1;
`endif
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            busy_q    <= 1'b0;
            ce_q      <= 1'b0;
            csb_q     <= 1'b1;
            web_q     <= 1'b1;
            oeb_q     <= 1'b1;
            addr_q    <= '0;
            idata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            id_q      <= id_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q    <= last_d;
`endif
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            busy_q    <= busy_d;
            ce_q      <= ce_d;
            csb_q     <= csb_d;
            web_q     <= web_d;
            oeb_q     <= oeb_d;
            addr_q    <= addr_d;
            idata_q   <= idata_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        id_d    = id_q;
        rd_done = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StAccess;
                    we_d    = winner ? WE1 : WE0;
                    id_d    = winner;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    last_d  = winner;
`endif
                end
            end
            StAccess: begin
                state_d = we_q ? StIdle : StWait;
                cnt_d   = 3'(RD_LAT - 1);
            end
            StWait: begin
                // cnt_q counts the WAIT cycles still to come after this one
                if (cnt_q == 3'd0) begin
                    state_d = StIdle;
                    rd_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_comb begin
        acc_d     = (state_d == StAccess);
        wait_d    = (state_d == StWait);
        ce_d      = acc_d || wait_d;
        csb_d     = !ce_d;
        web_d     = !(acc_d && we_d);
        oeb_d     = !((acc_d && !we_d) || wait_d);
        busy_d    = (state_d != StIdle);
        gnt0_d    = grant && !winner;
        gnt1_d    = grant && winner;
        rvalid0_d = rd_done && !id_q;
        rvalid1_d = rd_done && id_q;
        rdata_d   = rd_done ? ODATA : rdata_q;
        addr_d    = addr_q;
        idata_d   = idata_q;
        if (grant) begin
            addr_d  = winner ? ADDR1 : ADDR0;
            idata_d = winner ? WDATA1 : WDATA0;
        end
    end

    assign GNT0    = gnt0_q;
    assign GNT1    = gnt1_q;
    assign RVALID0 = rvalid0_q;
    assign RVALID1 = rvalid1_q;
    assign RDATA   = rdata_q;
    assign BUSY    = busy_q;
    assign ADDR    = addr_q;
    assign CE      = ce_q;
    assign CSB     = csb_q;
    assign WEB     = web_q;
    assign OEB     = oeb_q;
    assign IDATA   = idata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed vector table, arbitration and reset-abort sequences,
// and a randomized run against a transaction-level timing model.
module tb_mem_arb;

    localparam int RD_LAT = 2;
    localparam int AW     = 11;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ0, REQ1, WE0, WE1;
    logic [AW-1:0] ADDR0, ADDR1;
    logic [7:0]    WDATA0, WDATA1;
    logic          GNT0, GNT1, RVALID0, RVALID1;
    logic [7:0]    RDATA;
    logic          BUSY;
    logic [AW-1:0] ADDR;
    logic          CE, CSB, WEB, OEB;
    logic [7:0]    IDATA;
    logic [7:0]    ODATA;

    always #5 CLK = ~CLK;

    mem_arb #(.RD_LAT(RD_LAT), .AW(AW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
        .RDATA(RDATA), .BUSY(BUSY), .ADDR(ADDR),
        .CE(CE), .CSB(CSB), .WEB(WEB), .OEB(OEB),
        .IDATA(IDATA), .ODATA(ODATA)
    );

    int n_total = 0;
    int n_pass  = 0;

    typedef struct packed {
        logic        id;
        logic        we;
        logic [10:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  odata;
        logic        exp_web;
        logic        exp_oeb;
        logic [7:0]  exp_idata;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [6];

    int gid [8];
    int gcy [8];
    int n_g;

    // Random-run requester and model state
    bit          want [2];
    bit          rwe [2];
    logic [10:0] raddr [2];
    logic [7:0]  rwd [2];
    logic [7:0]  mem [2048];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic do_reset_chk(input string t);
        RST = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1; WE0 = 1'b1; WE1 = 1'b0;
        tick();
        tick();
        chk1({t, "_gnt0"}, GNT0, 1'b0);
        chk1({t, "_gnt1"}, GNT1, 1'b0);
        chk1({t, "_rvalid0"}, RVALID0, 1'b0);
        chk1({t, "_rvalid1"}, RVALID1, 1'b0);
        chk1({t, "_busy"}, BUSY, 1'b0);
        chk1({t, "_ce"}, CE, 1'b0);
        chk1({t, "_csb"}, CSB, 1'b1);
        chk1({t, "_web"}, WEB, 1'b1);
        chk1({t, "_oeb"}, OEB, 1'b1);
        chk({t, "_addr"}, 32'(ADDR), 32'd0);
        chk({t, "_idata"}, 32'(IDATA), 32'd0);
        chk({t, "_rdata"}, 32'(RDATA), 32'd0);
        REQ0 = 1'b0; REQ1 = 1'b0; RST = 1'b0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int cur;
        if (v.id) begin
            REQ1 = 1'b1; WE1 = v.we; ADDR1 = v.addr; WDATA1 = v.wdata;
        end else begin
            REQ0 = 1'b1; WE0 = v.we; ADDR0 = v.addr; WDATA0 = v.wdata;
        end
        ODATA = ~v.odata;
        tick();
        cur = 1;
        REQ0 = 1'b0; REQ1 = 1'b0;
        chk1($sformatf("v%0d_gnt0", i), GNT0, !v.id);
        chk1($sformatf("v%0d_gnt1", i), GNT1, v.id);
        chk1($sformatf("v%0d_ce", i), CE, 1'b1);
        chk1($sformatf("v%0d_csb", i), CSB, 1'b0);
        chk1($sformatf("v%0d_web", i), WEB, v.exp_web);
        chk1($sformatf("v%0d_oeb", i), OEB, v.exp_oeb);
        chk1($sformatf("v%0d_busy", i), BUSY, 1'b1);
        chk($sformatf("v%0d_addr", i), 32'(ADDR), 32'(v.addr));
        chk($sformatf("v%0d_idata", i), 32'(IDATA), 32'(v.exp_idata));
        if (v.we) begin
            tick();
            chk1($sformatf("v%0d_idle_ce", i), CE, 1'b0);
            chk1($sformatf("v%0d_idle_web", i), WEB, 1'b1);
            chk1($sformatf("v%0d_idle_busy", i), BUSY, 1'b0);
            chk1($sformatf("v%0d_no_rvalid", i), RVALID0 || RVALID1, 1'b0);
            chk($sformatf("v%0d_addr_hold", i), 32'(ADDR), 32'(v.addr));
            chk($sformatf("v%0d_rdata_hold", i), 32'(RDATA), 32'(v.exp_rdata));
        end else begin
            while (cur < RD_LAT + 2) begin
                // Memory presents data RD_LAT cycles after the access cycle, junk otherwise
                ODATA = (cur == RD_LAT + 1) ? v.odata : ~v.odata;
                tick();
                cur++;
                if (cur <= RD_LAT + 1) begin
                    chk1($sformatf("v%0d_oeb_c%0d", i, cur), OEB, 1'b0);
                    chk1($sformatf("v%0d_early_rv_c%0d", i, cur), RVALID0 || RVALID1, 1'b0);
                end else begin
                    chk1($sformatf("v%0d_rvalid0", i), RVALID0, !v.id);
                    chk1($sformatf("v%0d_rvalid1", i), RVALID1, v.id);
                    chk($sformatf("v%0d_rdata", i), 32'(RDATA), 32'(v.exp_rdata));
                    chk1($sformatf("v%0d_end_oeb", i), OEB, 1'b1);
                    chk1($sformatf("v%0d_end_busy", i), BUSY, 1'b0);
                end
            end
        end
    endtask

    task automatic collect(input int want_n, input int budget);
        n_g = 0;
        for (int c = 1; c <= budget && n_g < want_n; c++) begin
            tick();
            if (GNT0 || GNT1) begin
                gid[n_g] = GNT1 ? 1 : 0;
                gcy[n_g] = c;
                n_g++;
            end
        end
    endtask

    function automatic logic [10:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 11'h000;
            1:       return 11'h7FF;
            default: return 11'($urandom);
        endcase
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, free_at, g, rv_seen;
        bit t_we, t_id, m_last, w;
        logic [10:0] m_addr;
        logic [7:0] m_idata, m_rdata, t_rd;
        bit in_acc, in_wait, rv;

        vecs[0] = '{id:1'b0, we:1'b1, addr:11'h123, wdata:8'hA5, odata:8'h00,
                    exp_web:1'b0, exp_oeb:1'b1, exp_idata:8'hA5, exp_rdata:8'h00};
        vecs[1] = '{id:1'b1, we:1'b0, addr:11'h123, wdata:8'h3C, odata:8'hA5,
                    exp_web:1'b1, exp_oeb:1'b0, exp_idata:8'h3C, exp_rdata:8'hA5};
        vecs[2] = '{id:1'b0, we:1'b1, addr:11'h000, wdata:8'h5A, odata:8'h00,
                    exp_web:1'b0, exp_oeb:1'b1, exp_idata:8'h5A, exp_rdata:8'hA5};
        vecs[3] = '{id:1'b1, we:1'b0, addr:11'h7FF, wdata:8'h00, odata:8'hC3,
                    exp_web:1'b1, exp_oeb:1'b0, exp_idata:8'h00, exp_rdata:8'hC3};
        vecs[4] = '{id:1'b1, we:1'b1, addr:11'h7FF, wdata:8'hFF, odata:8'h00,
                    exp_web:1'b0, exp_oeb:1'b1, exp_idata:8'hFF, exp_rdata:8'hC3};
        vecs[5] = '{id:1'b0, we:1'b0, addr:11'h000, wdata:8'h11, odata:8'h7E,
                    exp_web:1'b1, exp_oeb:1'b0, exp_idata:8'h11, exp_rdata:8'h7E};

        RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
        ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0; ODATA = '0;

        do_reset_chk("rst0");

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Both requesters hold write requests continuously
        do_reset();
        REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 11'h010; WDATA0 = 8'h01;
        REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 11'h020; WDATA1 = 8'h02;
        collect(4, 20);
        REQ0 = 1'b0; REQ1 = 1'b0;
        chk("tie_count", n_g, 4);
        if (n_g > 0) chk("tie_first_cycle", gcy[0], 1);
        for (int i = 0; i < n_g; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            chk($sformatf("tie_order%0d", i), gid[i], 0);
`else
            chk($sformatf("tie_order%0d", i), gid[i], i % 2);
`endif
            if (i > 0) chk($sformatf("wr_spacing%0d", i), gcy[i] - gcy[i-1], 2);
        end
        tick();
        tick();

        // Back-to-back reads from one requester
        REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 11'h7FF; ODATA = 8'h33;
        collect(2, 20);
        REQ1 = 1'b0;
        chk("rd_count", n_g, 2);
        if (n_g == 2) chk("rd_spacing", gcy[1] - gcy[0], RD_LAT + 2);
        for (int i = 0; i < RD_LAT + 2; i++) tick();

        // Reset during WAIT aborts the read
        do_reset();
        REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 11'h055; WDATA1 = 8'h00; ODATA = 8'h99;
        tick();
        REQ1 = 1'b0;
        chk1("abort_gnt1", GNT1, 1'b1);
        tick();
        chk1("abort_wait_oeb", OEB, 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk1("abort_csb", CSB, 1'b1);
        chk1("abort_oeb", OEB, 1'b1);
        chk1("abort_ce", CE, 1'b0);
        chk1("abort_busy", BUSY, 1'b0);
        rv_seen = (RVALID0 || RVALID1) ? 1 : 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (RVALID0 || RVALID1) rv_seen++;
        end
        chk("abort_no_rvalid", rv_seen, 0);

        // Randomized run: model tracks transactions by grant cycle and fixed latencies
        for (int a = 0; a < 2048; a++) mem[a] = 8'($urandom);
        do_reset();
        cyc = 0; free_at = 0; g = -100; t_we = 1'b1; t_id = 1'b0; t_rd = 8'h00;
        m_last = 1'b1; m_addr = '0; m_idata = '0; m_rdata = '0;
        want[0] = 1'b0; want[1] = 1'b0;
        for (int x = 0; x < 2; x++) begin
            rwe[x] = 1'b0; raddr[x] = '0; rwd[x] = '0;
        end
        for (int i = 0; i < 300; i++) begin
            for (int x = 0; x < 2; x++) begin
                if (!want[x] && $urandom_range(0, 2) == 0) begin
                    want[x]  = 1'b1;
                    rwe[x]   = 1'($urandom_range(0, 1));
                    raddr[x] = pick_addr();
                    rwd[x]   = 8'($urandom);
                end
            end
            REQ0 = want[0]; WE0 = rwe[0]; ADDR0 = raddr[0]; WDATA0 = rwd[0];
            REQ1 = want[1]; WE1 = rwe[1]; ADDR1 = raddr[1]; WDATA1 = rwd[1];
            ODATA = (!t_we && cyc == g + RD_LAT) ? t_rd : ~t_rd;
            if (cyc >= free_at && (want[0] || want[1])) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                w = !want[0];
`else
                // On a tie, the requester not granted last time wins
                if (want[0] && want[1]) w = (m_last == 1'b1) ? 1'b0 : 1'b1;
                else                    w = want[1];
`endif
                m_last  = w;
                g       = cyc + 1;
                t_we    = rwe[w];
                t_id    = w;
                m_addr  = raddr[w];
                m_idata = rwd[w];
                if (t_we) begin
                    mem[m_addr] = m_idata;
                    free_at = cyc + 2;
                end else begin
                    t_rd = mem[m_addr];
                    free_at = cyc + RD_LAT + 2;
                end
            end
            tick();
            cyc++;
            in_acc  = (cyc == g);
            in_wait = !t_we && cyc > g && cyc <= g + RD_LAT;
            rv      = !t_we && cyc == g + RD_LAT + 1;
            if (rv) m_rdata = t_rd;
            chk1($sformatf("rnd_c%0d_gnt0", cyc), GNT0, in_acc && !t_id);
            chk1($sformatf("rnd_c%0d_gnt1", cyc), GNT1, in_acc && t_id);
            chk1($sformatf("rnd_c%0d_rvalid0", cyc), RVALID0, rv && !t_id);
            chk1($sformatf("rnd_c%0d_rvalid1", cyc), RVALID1, rv && t_id);
            chk1($sformatf("rnd_c%0d_busy", cyc), BUSY, in_acc || in_wait);
            chk1($sformatf("rnd_c%0d_ce", cyc), CE, in_acc || in_wait);
            chk1($sformatf("rnd_c%0d_csb", cyc), CSB, !(in_acc || in_wait));
            chk1($sformatf("rnd_c%0d_web", cyc), WEB, !(in_acc && t_we));
            chk1($sformatf("rnd_c%0d_oeb", cyc), OEB, !((in_acc && !t_we) || in_wait));
            chk($sformatf("rnd_c%0d_addr", cyc), 32'(ADDR), 32'(m_addr));
            chk($sformatf("rnd_c%0d_idata", cyc), 32'(IDATA), 32'(m_idata));
            chk($sformatf("rnd_c%0d_rdata", cyc), 32'(RDATA), 32'(m_rdata));
            chk1($sformatf("rnd_c%0d_excl", cyc),
                 ($countones({GNT0, GNT1, RVALID0, RVALID1}) <= 1), 1'b1);
            if (in_acc) want[t_id] = 1'b0;
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        for (int i = 0; i < RD_LAT + 3; i++) tick();

        do_reset_chk("rst1");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
